// File: rtl/uart_apb_tx_sched.sv
// uart_apb_tx_sched: APB master sharing the UART TX register among NREQ
// byte requesters; config write on reset exit, full-poll backoff, timeout.
module uart_apb_tx_sched #(
    parameter int         NREQ     = 2,
    parameter logic [7:0] CFG_VAL  = 8'h03,
    parameter int         POLL_GAP = 16,
    parameter int         TIMEOUT  = 64
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [1:0]        grant_id,
    output logic [3:0]        paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [7:0]        pwdata,
    input  logic [7:0]        prdata,
    input  logic              pready,
    output logic              cfg_done,
    output logic              err_to
);
    localparam logic [3:0] CFG_SETUP   = 4'd0;
    localparam logic [3:0] CFG_ACCESS  = 4'd1;
    localparam logic [3:0] IDLE        = 4'd2;
    localparam logic [3:0] POLL_SETUP  = 4'd3;
    localparam logic [3:0] POLL_ACCESS = 4'd4;
    localparam logic [3:0] POLL_CAPT   = 4'd5;
    localparam logic [3:0] BACKOFF     = 4'd6;
    localparam logic [3:0] WR_SETUP    = 4'd7;
    localparam logic [3:0] WR_ACCESS   = 4'd8;

    localparam int CMAX = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    logic [3:0]      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic            cfg_done_q, cfg_done_d;
    logic            err_q, err_d;

    logic [3:0]  valid_ext;
    logic [31:0] data_ext;
    logic        arb_hit;
    logic [1:0]  arb_id;
    logic [2:0]  arb_sum;
    logic [1:0]  rr_next;
    logic        to_hit;
    logic        gap_hit;
    logic        unused_prdata;

    assign valid_ext     = 4'(req_valid);
    assign data_ext      = 32'(req_data);
    assign rr_next       = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
    assign to_hit        = (cnt_q == CW'(TIMEOUT - 1));
    assign gap_hit       = (cnt_q == CW'(POLL_GAP - 1));
    assign unused_prdata = ^prdata[7:1];

    // Walk downward so the candidate closest to the pointer wins last.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = 2'd0;
        arb_sum = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_sum = {1'b0, rr_q} + 3'(k);
            if (arb_sum >= 3'(NREQ)) arb_sum = arb_sum - 3'(NREQ);
            if (valid_ext[arb_sum[1:0]]) begin
                arb_hit = 1'b1;
                arb_id  = arb_sum[1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        ready_d    = '0;
        cfg_done_d = cfg_done_q;
        err_d      = err_q;
        unique case (state_q)
            CFG_SETUP: begin
                state_d = CFG_ACCESS;
                cnt_d   = '0;
            end
            CFG_ACCESS: begin
                if (pready) begin
                    cfg_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                // An aborted config write is retried from here.
                if (!cfg_done_q) begin
                    state_d = CFG_SETUP;
                end else if (arb_hit) begin
                    grant_d = arb_id;
                    state_d = POLL_SETUP;
                end
            end
            POLL_SETUP: begin
                state_d = POLL_ACCESS;
                cnt_d   = '0;
            end
            POLL_ACCESS: begin
                if (pready) begin
                    state_d = POLL_CAPT;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            POLL_CAPT: begin
                if (prdata[0]) begin
                    state_d = BACKOFF;
                    cnt_d   = '0;
                end else begin
                    state_d = WR_SETUP;
                    wdata_d = data_ext[{grant_q, 3'b000} +: 8];
                end
            end
            BACKOFF: begin
                if (gap_hit) state_d = POLL_SETUP;
                else cnt_d = cnt_q + CW'(1);
            end
            WR_SETUP: begin
                state_d = WR_ACCESS;
                cnt_d   = '0;
            end
            WR_ACCESS: begin
                if (pready) begin
                    ready_d = NREQ'(1) << grant_q;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = CFG_SETUP;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 4'h0;
        pwdata  = 8'h00;
        case (state_q)
            CFG_SETUP, CFG_ACCESS: begin
                psel    = 1'b1;
                penable = (state_q == CFG_ACCESS);
                pwrite  = 1'b1;
                pwdata  = CFG_VAL;
            end
            POLL_SETUP, POLL_ACCESS: begin
                psel    = 1'b1;
                penable = (state_q == POLL_ACCESS);
                paddr   = 4'h2;
            end
            WR_SETUP, WR_ACCESS: begin
                psel    = 1'b1;
                penable = (state_q == WR_ACCESS);
                pwrite  = 1'b1;
                paddr   = 4'h2;
                pwdata  = wdata_q;
            end
            default: ;
        endcase
        // Bus stays quiet for as long as reset is held.
        if (preset) begin
            psel    = 1'b0;
            penable = 1'b0;
            pwrite  = 1'b0;
            paddr   = 4'h0;
            pwdata  = 8'h00;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= CFG_SETUP;
            grant_q    <= 2'd0;
            rr_q       <= 2'd0;
            cnt_q      <= '0;
            wdata_q    <= 8'h00;
            ready_q    <= '0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign grant_id  = grant_q;
    assign cfg_done  = cfg_done_q;
    assign err_to    = err_q;
endmodule
